fifo_ptr_ctrl: RTL

- Pointer and arbitration controller for the single-clock FIFO.
- Sits directly upstream of the FIFO dual-port memory block:
  - accepts held write/read requests from producer and consumer;
  - drives the memory's `fifo_we`, `fifo_rd`, `wptr` and `rptr`;
  - maintains full/empty state, threshold flags, an occupancy count and sticky error flags.
- The memory performs only one access per cycle, with write taking precedence. This block therefore never asserts `fifo_we` and `fifo_rd` together; it arbitrates between them.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ptr_cnt.sv | 20 ++
 rtl/fifo_ptr_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the single-clock FIFO pointer controller.
package fifo_pkg;

  // Default memory address width; pointers carry one extra wrap bit.
  localparam int DEF_ADDR_WIDTH = 3;

  // Occupancy state of the FIFO.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MID   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  // Side that won the most recent contended arbitration.
  localparam logic GNT_WR = 1'b0;
  localparam logic GNT_RD = 1'b1;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrap-around pointer: W bits, the MSB toggles once per lap of the memory.
module fifo_ptr_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Advance by one on each granted access; natural modulo 2^W wrap.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, arbitration and status controller sitting in front of the FIFO
// dual-port memory. The memory does one access per cycle, so a write and a
// read are never granted together.
//
// Handshake: wr_req / rd_req are level requests held by the requester until
// the matching grant (fifo_we / fifo_rd) is seen high in the same cycle; the
// transfer happens at the rising edge where request and grant are both high.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic                  clr_err,
  output logic                  fifo_we,
  output logic                  fifo_rd,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  rd_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_afull,
  output logic                  fifo_aempty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  output logic                  underflow,
  output fifo_state_t           dbg_state
);

  localparam int FIFO_DEPTH = 1 << ADDR_WIDTH;
  localparam int CW         = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_M1 = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] AFULL_T  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_T = CW'(AEMPTY_THRESH);

  fifo_state_t   state;
  fifo_state_t   state_nxt;
  logic          we_ok;
  logic          rd_ok;
  logic          last_gnt;
  logic          last_gnt_nxt;
  logic [CW-1:0] cnt_nxt;

  assign fifo_full  = (state == FULL);
  assign fifo_empty = (state == EMPTY);
  assign dbg_state  = state;

  // Eligibility and arbitration: contended cycles go to the side that lost
  // the previous contention; grants are forced low while reset is asserted.
  always_comb begin
    we_ok        = rstn & wr_req & ~fifo_full;
    rd_ok        = rstn & rd_req & ~fifo_empty;
    fifo_we      = we_ok;
    fifo_rd      = rd_ok;
    last_gnt_nxt = last_gnt;
    if (we_ok && rd_ok) begin
      if (last_gnt == GNT_RD) begin
        fifo_rd      = 1'b0;
        last_gnt_nxt = GNT_WR;
      end else begin
        fifo_we      = 1'b0;
        last_gnt_nxt = GNT_RD;
      end
    end
  end

  // Next occupancy; at most one grant per cycle so the step is +-1.
  always_comb begin
    cnt_nxt = fifo_count;
    if (fifo_we) begin
      cnt_nxt = fifo_count + CNT_ONE;
    end else if (fifo_rd) begin
      cnt_nxt = fifo_count - CNT_ONE;
    end
  end

  // Next-state logic for the EMPTY / MID / FULL occupancy FSM.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (fifo_we) state_nxt = (FIFO_DEPTH == 1) ? FULL : MID;
      MID: begin
        if (fifo_we && fifo_count == DEPTH_M1) begin
          state_nxt = FULL;
        end else if (fifo_rd && fifo_count == CNT_ONE) begin
          state_nxt = EMPTY;
        end
      end
      FULL:  if (fifo_rd) state_nxt = (FIFO_DEPTH == 1) ? EMPTY : MID;
      default: state_nxt = EMPTY;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Count, threshold flags, sticky errors, read-data valid and last grant.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fifo_count  <= '0;
      fifo_afull  <= 1'b0;
      fifo_aempty <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      rd_valid    <= 1'b0;
      last_gnt    <= GNT_RD;
    end else begin
      fifo_count  <= cnt_nxt;
      fifo_afull  <= (cnt_nxt >= AFULL_T);
      fifo_aempty <= (cnt_nxt <= AEMPTY_T);
      // A fresh error in the clearing cycle keeps the flag set.
      overflow    <= (wr_req & fifo_full)  | (overflow  & ~clr_err);
      underflow   <= (rd_req & fifo_empty) | (underflow & ~clr_err);
      rd_valid    <= fifo_rd;
      last_gnt    <= last_gnt_nxt;
    end
  end

  fifo_ptr_cnt #(.W(CW)) u_wptr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (fifo_we),
    .ptr  (wptr)
  );

  fifo_ptr_cnt #(.W(CW)) u_rptr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (fifo_rd),
    .ptr  (rptr)
  );

endmodule
